// File: rtl/arcade_input_mapper.sv
// -----------------------------------------------------------------------------
// arcade_input_mapper
//
// Player-input front end for arcade cores. PS/2 key events from hps_io are
// latched per key and ORed with the HPS joysticks to form per-player direction,
// button, start and coin signals. Directions can be rotated for
// horizontal-monitor play, and coin requests are stretched to a fixed-width
// pulse.
//
// Parameters
//   PLAYERS      number of players, 1..4 (keyboard covers P1/P2 only)
//   NBTN         fire buttons per player, 1..4
//   COIN_CYCLES  coin output high time in clock cycles, >= 1
//
// Ports
//   i_clk_sys          system clock
//   i_reset            synchronous, active-high reset
//   i_ps2_key          [10] toggle, [9] pressed, [8:0] scan code
//   i_joy_in           joystick i at [16*i +: 16]:
//                      [0] R [1] L [2] D [3] U [4 +: NBTN] buttons,
//                      [4+NBTN] start, [5+NBTN] coin
//   i_rotate           0 none, 1 horizontal CW, 2 horizontal CCW, 3 as 0
//   i_coin_from_start  a start rising edge also inserts a coin
//   o_up/o_down/o_left/o_right  registered, rotated directions, bit i = player i
//   o_btn              player i at [NBTN*i +: NBTN]
//   o_start            registered start
//   o_coin             stretched coin pulse
// -----------------------------------------------------------------------------
module arcade_input_mapper #(
   parameter int unsigned PLAYERS     = 2,
   parameter int unsigned NBTN        = 1,
   parameter logic [15:0] COIN_CYCLES = 16'd60000
) (
   input  logic                      i_clk_sys,
   input  logic                      i_reset,
   input  logic [10:0]               i_ps2_key,
   input  logic [16*PLAYERS-1:0]     i_joy_in,
   input  logic [1:0]                i_rotate,
   input  logic                      i_coin_from_start,
   output logic [PLAYERS-1:0]        o_up,
   output logic [PLAYERS-1:0]        o_down,
   output logic [PLAYERS-1:0]        o_left,
   output logic [PLAYERS-1:0]        o_right,
   output logic [NBTN*PLAYERS-1:0]   o_btn,
   output logic [PLAYERS-1:0]        o_start,
   output logic [PLAYERS-1:0]        o_coin
);

   // Keys are only latched for players and buttons that exist.
   localparam logic [1:0] KEY_PMASK = (PLAYERS >= 2) ? 2'b11 : 2'b01;
   localparam logic [3:0] BTN_MASK1 = 4'((32'd1 << NBTN) - 32'd1);
   localparam logic [7:0] KEY_BMASK = {((PLAYERS >= 2) ? BTN_MASK1 : 4'b0000), BTN_MASK1};

   // Keyboard latches, index = player (0/1); buttons at [4*player + button].
   logic       r_old_toggle;
   logic [1:0] r_ku, r_kd, r_kl, r_kr, r_ks, r_kc;
   logic [7:0] r_kb;
   logic [1:0] w_ku_d, w_kd_d, w_kl_d, w_kr_d, w_ks_d, w_kc_d;
   logic [7:0] w_kb_d;

   logic       w_event;
   logic       w_pressed;
   logic [8:0] w_code;

   logic [PLAYERS-1:0]      w_raw_u, w_raw_d, w_raw_l, w_raw_r;
   logic [PLAYERS-1:0]      w_raw_start, w_raw_coin;
   logic [NBTN*PLAYERS-1:0] w_raw_btn;
   logic [PLAYERS-1:0]      w_up, w_down, w_left, w_right;
   logic [PLAYERS-1:0]      w_trig;

   logic [PLAYERS-1:0]      r_up, r_down, r_left, r_right, r_start;
   logic [NBTN*PLAYERS-1:0] r_btn;
   logic [PLAYERS-1:0]      r_prev_coin, r_prev_start;

   assign w_event   = i_ps2_key[10] != r_old_toggle;
   assign w_pressed = i_ps2_key[9];
   assign w_code    = i_ps2_key[8:0];

   // Key decode: a toggle change marks one event; the matching latch takes the
   // pressed bit.
   always_comb begin
      w_ku_d = r_ku;
      w_kd_d = r_kd;
      w_kl_d = r_kl;
      w_kr_d = r_kr;
      w_ks_d = r_ks;
      w_kc_d = r_kc;
      w_kb_d = r_kb;
      if (w_event) begin
         // Arrow keys arrive with or without the extended prefix bit.
         if (w_code[7:0] == 8'h75) w_ku_d[0] = w_pressed;
         if (w_code[7:0] == 8'h72) w_kd_d[0] = w_pressed;
         if (w_code[7:0] == 8'h6B) w_kl_d[0] = w_pressed;
         if (w_code[7:0] == 8'h74) w_kr_d[0] = w_pressed;
         case (w_code)
            9'h014, 9'h029: w_kb_d[0] = w_pressed;
            9'h011:         w_kb_d[1] = w_pressed;
            9'h012:         w_kb_d[2] = w_pressed;
            9'h01A:         w_kb_d[3] = w_pressed;
            9'h016, 9'h005: w_ks_d[0] = w_pressed;
            9'h02E:         w_kc_d[0] = w_pressed;
            9'h02D:         w_ku_d[1] = w_pressed;
            9'h02B:         w_kd_d[1] = w_pressed;
            9'h023:         w_kl_d[1] = w_pressed;
            9'h034:         w_kr_d[1] = w_pressed;
            9'h01C:         w_kb_d[4] = w_pressed;
            9'h01B:         w_kb_d[5] = w_pressed;
            9'h015:         w_kb_d[6] = w_pressed;
            9'h01D:         w_kb_d[7] = w_pressed;
            9'h01E, 9'h006: w_ks_d[1] = w_pressed;
            9'h036:         w_kc_d[1] = w_pressed;
            default:        ;
         endcase
      end
      w_ku_d = w_ku_d & KEY_PMASK;
      w_kd_d = w_kd_d & KEY_PMASK;
      w_kl_d = w_kl_d & KEY_PMASK;
      w_kr_d = w_kr_d & KEY_PMASK;
      w_ks_d = w_ks_d & KEY_PMASK;
      w_kc_d = w_kc_d & KEY_PMASK;
      w_kb_d = w_kb_d & KEY_BMASK;
   end

   for (genvar p = 0; p < PLAYERS; p++) begin : g_player
      logic [3:0]      w_kdir;   // {U, D, L, R}
      logic [NBTN-1:0] w_kbtn;
      logic            w_kstart;
      logic            w_kcoin;
      logic            r_coin;
      logic [15:0]     r_cnt;

      if (p < 2) begin : g_kb
         assign w_kdir   = {r_ku[p], r_kd[p], r_kl[p], r_kr[p]};
         assign w_kbtn   = r_kb[4*p +: NBTN];
         assign w_kstart = r_ks[p];
         assign w_kcoin  = r_kc[p];
      end else begin : g_nokb
         assign w_kdir   = 4'b0000;
         assign w_kbtn   = '0;
         assign w_kstart = 1'b0;
         assign w_kcoin  = 1'b0;
      end

      assign w_raw_r[p]     = i_joy_in[16*p + 0] | w_kdir[0];
      assign w_raw_l[p]     = i_joy_in[16*p + 1] | w_kdir[1];
      assign w_raw_d[p]     = i_joy_in[16*p + 2] | w_kdir[2];
      assign w_raw_u[p]     = i_joy_in[16*p + 3] | w_kdir[3];
      assign w_raw_start[p] = i_joy_in[16*p + 4 + NBTN] | w_kstart;
      assign w_raw_coin[p]  = i_joy_in[16*p + 5 + NBTN] | w_kcoin;
      assign w_raw_btn[NBTN*p +: NBTN] = i_joy_in[16*p + 4 +: NBTN] | w_kbtn;

      // Pulse stretcher: a trigger only arms an idle stretcher, so a held or
      // repeated request never extends a pulse already running.
      always_ff @(posedge i_clk_sys) begin
         if (i_reset) begin
            r_coin <= 1'b0;
            r_cnt  <= 16'd0;
         end else if (r_coin) begin
            if (r_cnt == 16'd0) r_coin <= 1'b0;
            else                r_cnt  <= r_cnt - 16'd1;
         end else if (w_trig[p]) begin
            r_coin <= 1'b1;
            r_cnt  <= COIN_CYCLES - 16'd1;
         end
      end

      assign o_coin[p] = r_coin;
   end

   // Coin and start edges in the same cycle collapse into one trigger.
   assign w_trig = (w_raw_coin & ~r_prev_coin)
                 | ({PLAYERS{i_coin_from_start}} & w_raw_start & ~r_prev_start);

   always_comb begin
      w_up    = w_raw_u;
      w_down  = w_raw_d;
      w_left  = w_raw_l;
      w_right = w_raw_r;
      case (i_rotate)
         2'd1: begin
            w_up    = w_raw_l;
            w_down  = w_raw_r;
            w_left  = w_raw_d;
            w_right = w_raw_u;
         end
         2'd2: begin
            w_up    = w_raw_r;
            w_down  = w_raw_l;
            w_left  = w_raw_u;
            w_right = w_raw_d;
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk_sys) begin
      // Tracking the toggle through reset avoids a phantom event on release.
      r_old_toggle <= i_ps2_key[10];
      if (i_reset) begin
         r_ku         <= '0;
         r_kd         <= '0;
         r_kl         <= '0;
         r_kr         <= '0;
         r_ks         <= '0;
         r_kc         <= '0;
         r_kb         <= '0;
         r_up         <= '0;
         r_down       <= '0;
         r_left       <= '0;
         r_right      <= '0;
         r_btn        <= '0;
         r_start      <= '0;
         r_prev_coin  <= '0;
         r_prev_start <= '0;
      end else begin
         r_ku         <= w_ku_d;
         r_kd         <= w_kd_d;
         r_kl         <= w_kl_d;
         r_kr         <= w_kr_d;
         r_ks         <= w_ks_d;
         r_kc         <= w_kc_d;
         r_kb         <= w_kb_d;
         r_up         <= w_up;
         r_down       <= w_down;
         r_left       <= w_left;
         r_right      <= w_right;
         r_btn        <= w_raw_btn;
         r_start      <= w_raw_start;
         r_prev_coin  <= w_raw_coin;
         r_prev_start <= w_raw_start;
      end
   end

   assign o_up    = r_up;
   assign o_down  = r_down;
   assign o_left  = r_left;
   assign o_right = r_right;
   assign o_btn   = r_btn;
   assign o_start = r_start;

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Bench for arcade_input_mapper: DUT "a" uses PLAYERS=2/NBTN=1, DUT "b" uses
// PLAYERS=4/NBTN=3, both with a 5-cycle coin pulse. Each stimulus cycle pushes
// the expected outputs of both DUTs; a checker per scenario pops and compares.
module tb_arcade_input_mapper;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [10:0] a_ps2 = '0;
   logic [10:0] b_ps2 = '0;
   logic [31:0] a_joy = '0;
   logic [63:0] b_joy = '0;
   logic [1:0]  a_rot = 2'd0;
   logic        a_cfs = 1'b0;

   logic [1:0]  a_up, a_down, a_left, a_right, a_btn, a_start, a_coin;
   logic [3:0]  b_up, b_down, b_left, b_right, b_start, b_coin;
   logic [11:0] b_btn;

   arcade_input_mapper #(.PLAYERS(2), .NBTN(1), .COIN_CYCLES(16'd5)) u_dut_a (
      .i_clk_sys(clk), .i_reset(rst), .i_ps2_key(a_ps2), .i_joy_in(a_joy),
      .i_rotate(a_rot), .i_coin_from_start(a_cfs),
      .o_up(a_up), .o_down(a_down), .o_left(a_left), .o_right(a_right),
      .o_btn(a_btn), .o_start(a_start), .o_coin(a_coin)
   );

   arcade_input_mapper #(.PLAYERS(4), .NBTN(3), .COIN_CYCLES(16'd5)) u_dut_b (
      .i_clk_sys(clk), .i_reset(rst), .i_ps2_key(b_ps2), .i_joy_in(b_joy),
      .i_rotate(2'd0), .i_coin_from_start(1'b0),
      .o_up(b_up), .o_down(b_down), .o_left(b_left), .o_right(b_right),
      .o_btn(b_btn), .o_start(b_start), .o_coin(b_coin)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [13:0] a;
      logic [35:0] b;
   } exp_t;

   wire [13:0] a_obs = {a_up, a_down, a_left, a_right, a_btn, a_start, a_coin};
   wire [35:0] b_obs = {b_up, b_down, b_left, b_right, b_btn, b_start, b_coin};

   localparam logic [13:0] AZ = '0;
   localparam logic [35:0] BZ = '0;

   exp_t q[$];
   exp_t e;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   idx     = 0;
   bit   drv_done;

   function automatic logic [13:0] ex(input logic [1:0] u, d, l, r, b, s, c);
      return {u, d, l, r, b, s, c};
   endfunction

   function automatic logic [35:0] exb(input logic [11:0] btn);
      return {16'h0000, btn, 8'h00};
   endfunction

   // Queue the expected outputs for the sample after the next edge, then step.
   task cyc(input logic [13:0] ea, input logic [35:0] eb);
      q.push_back({ea, eb});
      @(posedge clk);
      #1;
   endtask

   task send_a(input logic [8:0] code, input logic pressed);
      a_ps2 = {~a_ps2[10], pressed, code};
   endtask

   task send_b(input logic [8:0] code, input logic pressed);
      b_ps2 = {~b_ps2[10], pressed, code};
   endtask

   task test_reset;
      rst   = 1'b1;
      a_ps2 = {1'b1, 1'b1, 9'h175};
      b_ps2 = {1'b1, 1'b1, 9'h01C};
      repeat (3) @(posedge clk);
      #1;
      drv_done = 0;
      idx = 0;
      fork
         begin
            rst = 1'b0;
            repeat (10) cyc(AZ, BZ);
            drv_done = 1;
         end
         begin
            while (!drv_done || q.size() != 0) begin
               @(posedge clk);
               #1;
               if (q.size() != 0) begin
                  e = q.pop_front();
                  n_tests++;
                  if ({a_obs, b_obs} !== e)
                     $display("FAIL reset[%0d]: got a=%h b=%h expected a=%h b=%h",
                              idx, a_obs, b_obs, e.a, e.b);
                  if ({a_obs, b_obs} !== e) n_fail++;
                  idx++;
               end
            end
         end
      join
   endtask

   task test_key_arrow;
      drv_done = 0;
      idx = 0;
      fork
         begin
            send_a(9'h175, 1'b1);
            cyc(AZ, BZ);
            repeat (2) cyc(ex(2'b01, 0, 0, 0, 0, 0, 0), BZ);
            send_a(9'h175, 1'b0);
            cyc(ex(2'b01, 0, 0, 0, 0, 0, 0), BZ);
            repeat (2) cyc(AZ, BZ);
            send_a(9'h075, 1'b1);
            cyc(AZ, BZ);
            repeat (2) cyc(ex(2'b01, 0, 0, 0, 0, 0, 0), BZ);
            a_rot = 2'd1;
            repeat (2) cyc(ex(0, 0, 0, 2'b01, 0, 0, 0), BZ);
            send_a(9'h075, 1'b0);
            cyc(ex(0, 0, 0, 2'b01, 0, 0, 0), BZ);
            repeat (2) cyc(AZ, BZ);
            a_rot = 2'd0;
            send_a(9'h02D, 1'b1);
            cyc(AZ, BZ);
            repeat (2) cyc(ex(2'b10, 0, 0, 0, 0, 0, 0), BZ);
            send_a(9'h02D, 1'b0);
            cyc(ex(2'b10, 0, 0, 0, 0, 0, 0), BZ);
            repeat (2) cyc(AZ, BZ);
            drv_done = 1;
         end
         begin
            while (!drv_done || q.size() != 0) begin
               @(posedge clk);
               #1;
               if (q.size() != 0) begin
                  e = q.pop_front();
                  n_tests++;
                  if ({a_obs, b_obs} !== e)
                     $display("FAIL key_arrow[%0d]: got a=%h b=%h expected a=%h b=%h",
                              idx, a_obs, b_obs, e.a, e.b);
                  if ({a_obs, b_obs} !== e) n_fail++;
                  idx++;
               end
            end
         end
      join
   endtask

   task test_rotate_joy;
      drv_done = 0;
      idx = 0;
      fork
         begin
            a_joy[0]  = 1'b1;   // P1 right
            a_joy[17] = 1'b1;   // P2 left
            a_rot = 2'd0;
            cyc(ex(0, 0, 2'b10, 2'b01, 0, 0, 0), BZ);
            a_rot = 2'd2;
            cyc(ex(2'b01, 2'b10, 0, 0, 0, 0, 0), BZ);
            a_rot = 2'd1;
            cyc(ex(2'b10, 2'b01, 0, 0, 0, 0, 0), BZ);
            a_rot = 2'd3;
            cyc(ex(0, 0, 2'b10, 2'b01, 0, 0, 0), BZ);
            a_joy = '0;
            a_rot = 2'd0;
            cyc(AZ, BZ);
            drv_done = 1;
         end
         begin
            while (!drv_done || q.size() != 0) begin
               @(posedge clk);
               #1;
               if (q.size() != 0) begin
                  e = q.pop_front();
                  n_tests++;
                  if ({a_obs, b_obs} !== e)
                     $display("FAIL rotate_joy[%0d]: got a=%h b=%h expected a=%h b=%h",
                              idx, a_obs, b_obs, e.a, e.b);
                  if ({a_obs, b_obs} !== e) n_fail++;
                  idx++;
               end
            end
         end
      join
   endtask

   task test_buttons;
      drv_done = 0;
      idx = 0;
      fork
         begin
            send_a(9'h014, 1'b1);
            cyc(AZ, BZ);
            cyc(ex(0, 0, 0, 0, 2'b01, 0, 0), BZ);
            send_a(9'h014, 1'b0);
            cyc(ex(0, 0, 0, 0, 2'b01, 0, 0), BZ);
            cyc(AZ, BZ);
            send_a(9'h029, 1'b1);
            cyc(AZ, BZ);
            cyc(ex(0, 0, 0, 0, 2'b01, 0, 0), BZ);
            send_a(9'h029, 1'b0);
            cyc(ex(0, 0, 0, 0, 2'b01, 0, 0), BZ);
            cyc(AZ, BZ);
            send_a(9'h01C, 1'b1);
            cyc(AZ, BZ);
            cyc(ex(0, 0, 0, 0, 2'b10, 0, 0), BZ);
            send_a(9'h01C, 1'b0);
            cyc(ex(0, 0, 0, 0, 2'b10, 0, 0), BZ);
            cyc(AZ, BZ);
            send_a(9'h011, 1'b1);   // btn1 does not exist with one button
            repeat (3) cyc(AZ, BZ);
            send_a(9'h114, 1'b1);   // non-arrow codes need an exact match
            repeat (3) cyc(AZ, BZ);
            send_a(9'h016, 1'b1);
            cyc(AZ, BZ);
            repeat (6) cyc(ex(0, 0, 0, 0, 0, 2'b01, 0), BZ);
            send_a(9'h016, 1'b0);
            cyc(ex(0, 0, 0, 0, 0, 2'b01, 0), BZ);
            cyc(AZ, BZ);
            drv_done = 1;
         end
         begin
            while (!drv_done || q.size() != 0) begin
               @(posedge clk);
               #1;
               if (q.size() != 0) begin
                  e = q.pop_front();
                  n_tests++;
                  if ({a_obs, b_obs} !== e)
                     $display("FAIL buttons[%0d]: got a=%h b=%h expected a=%h b=%h",
                              idx, a_obs, b_obs, e.a, e.b);
                  if ({a_obs, b_obs} !== e) n_fail++;
                  idx++;
               end
            end
         end
      join
   endtask

   task test_coin_stretch;
      drv_done = 0;
      idx = 0;
      fork
         begin
            a_joy[6] = 1'b1;
            repeat (5) cyc(ex(0, 0, 0, 0, 0, 0, 2'b01), BZ);
            repeat (15) cyc(AZ, BZ);
            // Short press, release, press again while the pulse runs.
            a_joy[6] = 1'b0;
            repeat (2) cyc(AZ, BZ);
            a_joy[6] = 1'b1;
            repeat (2) cyc(ex(0, 0, 0, 0, 0, 0, 2'b01), BZ);
            a_joy[6] = 1'b0;
            cyc(ex(0, 0, 0, 0, 0, 0, 2'b01), BZ);
            a_joy[6] = 1'b1;
            repeat (2) cyc(ex(0, 0, 0, 0, 0, 0, 2'b01), BZ);
            repeat (6) cyc(AZ, BZ);
            a_joy[6] = 1'b0;
            repeat (2) cyc(AZ, BZ);
            a_joy[6] = 1'b1;
            repeat (5) cyc(ex(0, 0, 0, 0, 0, 0, 2'b01), BZ);
            a_joy[6] = 1'b0;
            repeat (3) cyc(AZ, BZ);
            drv_done = 1;
         end
         begin
            while (!drv_done || q.size() != 0) begin
               @(posedge clk);
               #1;
               if (q.size() != 0) begin
                  e = q.pop_front();
                  n_tests++;
                  if ({a_obs, b_obs} !== e)
                     $display("FAIL coin_stretch[%0d]: got a=%h b=%h expected a=%h b=%h",
                              idx, a_obs, b_obs, e.a, e.b);
                  if ({a_obs, b_obs} !== e) n_fail++;
                  idx++;
               end
            end
         end
      join
   endtask

   task test_coin_from_start;
      drv_done = 0;
      idx = 0;
      fork
         begin
            a_cfs = 1'b1;
            send_a(9'h01E, 1'b1);
            cyc(AZ, BZ);
            repeat (5) cyc(ex(0, 0, 0, 0, 0, 2'b10, 2'b10), BZ);
            repeat (2) cyc(ex(0, 0, 0, 0, 0, 2'b10, 0), BZ);
            send_a(9'h01E, 1'b0);
            cyc(ex(0, 0, 0, 0, 0, 2'b10, 0), BZ);
            repeat (2) cyc(AZ, BZ);
            a_cfs = 1'b0;
            send_a(9'h01E, 1'b1);
            cyc(AZ, BZ);
            repeat (7) cyc(ex(0, 0, 0, 0, 0, 2'b10, 0), BZ);
            send_a(9'h01E, 1'b0);
            cyc(ex(0, 0, 0, 0, 0, 2'b10, 0), BZ);
            repeat (2) cyc(AZ, BZ);
            // Start and coin rising together give one pulse.
            a_cfs = 1'b1;
            a_joy[21] = 1'b1;
            a_joy[22] = 1'b1;
            repeat (5) cyc(ex(0, 0, 0, 0, 0, 2'b10, 2'b10), BZ);
            repeat (3) cyc(ex(0, 0, 0, 0, 0, 2'b10, 0), BZ);
            a_joy = '0;
            a_cfs = 1'b0;
            repeat (2) cyc(AZ, BZ);
            drv_done = 1;
         end
         begin
            while (!drv_done || q.size() != 0) begin
               @(posedge clk);
               #1;
               if (q.size() != 0) begin
                  e = q.pop_front();
                  n_tests++;
                  if ({a_obs, b_obs} !== e)
                     $display("FAIL coin_from_start[%0d]: got a=%h b=%h expected a=%h b=%h",
                              idx, a_obs, b_obs, e.a, e.b);
                  if ({a_obs, b_obs} !== e) n_fail++;
                  idx++;
               end
            end
         end
      join
   endtask

   task test_wide_params;
      drv_done = 0;
      idx = 0;
      fork
         begin
            b_joy[16*3+6] = 1'b1;   // player 3, button 2
            repeat (3) cyc(AZ, exb(12'h800));
            send_b(9'h01D, 1'b1);   // P2 btn3 absent with three buttons
            repeat (3) cyc(AZ, exb(12'h800));
            send_b(9'h01C, 1'b1);
            cyc(AZ, exb(12'h800));
            repeat (2) cyc(AZ, exb(12'h808));
            send_b(9'h01C, 1'b0);
            b_joy = '0;
            cyc(AZ, exb(12'h008));
            repeat (2) cyc(AZ, BZ);
            drv_done = 1;
         end
         begin
            while (!drv_done || q.size() != 0) begin
               @(posedge clk);
               #1;
               if (q.size() != 0) begin
                  e = q.pop_front();
                  n_tests++;
                  if ({a_obs, b_obs} !== e)
                     $display("FAIL wide_params[%0d]: got a=%h b=%h expected a=%h b=%h",
                              idx, a_obs, b_obs, e.a, e.b);
                  if ({a_obs, b_obs} !== e) n_fail++;
                  idx++;
               end
            end
         end
      join
   endtask

   task test_reset_mid_pulse;
      drv_done = 0;
      idx = 0;
      fork
         begin
            a_joy[6] = 1'b1;
            cyc(ex(0, 0, 0, 0, 0, 0, 2'b01), BZ);
            a_joy[6] = 1'b0;
            repeat (2) cyc(ex(0, 0, 0, 0, 0, 0, 2'b01), BZ);
            rst = 1'b1;               // counter now holds 2
            cyc(AZ, BZ);
            rst = 1'b0;
            repeat (8) cyc(AZ, BZ);
            drv_done = 1;
         end
         begin
            while (!drv_done || q.size() != 0) begin
               @(posedge clk);
               #1;
               if (q.size() != 0) begin
                  e = q.pop_front();
                  n_tests++;
                  if ({a_obs, b_obs} !== e)
                     $display("FAIL reset_mid_pulse[%0d]: got a=%h b=%h expected a=%h b=%h",
                              idx, a_obs, b_obs, e.a, e.b);
                  if ({a_obs, b_obs} !== e) n_fail++;
                  idx++;
               end
            end
         end
      join
   endtask

   initial begin
      test_reset();
      test_key_arrow();
      test_rotate_joy();
      test_buttons();
      test_coin_stretch();
      test_coin_from_start();
      test_wide_params();
      test_reset_mid_pulse();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
